banked_data_memory: RTL

Parametrised synchronous data memory, successor to the single-port 8-bit-address / 16-bit-data `DataMemory`, and the datapath's load/store target. It adds a clock, registered reads with a valid strobe, and byte-enable writes. It also adds a hardware clear sequence after reset, with a `ready` handshake, and out-of-range address detection. Consumed by the CPU memory stage: one request per cycle, one-cycle read latency.

---
 rtl/banked_data_memory.sv | 114 +++++++++++
 1 files changed

// File: rtl/banked_data_memory.sv
// banked_data_memory
// Synchronous word memory with byte-enable writes, one-cycle registered reads
// and a read-valid strobe. After reset, a hardware sequence zero-fills every
// word before requests are accepted. Requests to an address at or above DEPTH
// report an address error instead of touching the array.
module banked_data_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH/8-1:0] byteEn,
    input  logic                    memRead,
    input  logic                    memWrite,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    readValid,
    output logic                    addrError
);

    localparam int NB = DATA_WIDTH / 8;

    // The clear counter is one bit wider than the address so that
    // DEPTH == 2**ADDR_WIDTH still has a representable last index and limit.
    localparam logic [ADDR_WIDTH:0] CLR_LAST  = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH:0]     r_clrAddr;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_readData;
    logic                    r_readValid;
    logic                    r_addrError;
    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                    w_inRange;
    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_oldWord;
    logic [DATA_WIDTH-1:0]   w_merged;

    assign w_inRange = ({1'b0, address} < ADDR_LIMIT);
    assign w_accept  = r_ready & (memRead | memWrite);

    // Old word at the request address overlaid with the enabled store bytes;
    // this is both the value written back and the write-first read result.
    always_comb begin
        w_oldWord = r_mem[address];
        w_merged  = w_oldWord;
        for (int i = 0; i < NB; i++) begin
            if (byteEn[i]) begin
                w_merged[8*i +: 8] = writeData[8*i +: 8];
            end
        end
    end

    // Control FSM: walks the clear counter, then services requests and
    // registers read data, read-valid and address-error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_CLEAR;
            r_clrAddr   <= '0;
            r_ready     <= 1'b0;
            r_readData  <= '0;
            r_readValid <= 1'b0;
            r_addrError <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_readValid <= 1'b0;
            r_addrError <= 1'b0;
            if (r_clrAddr == CLR_LAST) begin
                r_state   <= S_IDLE;
                r_ready   <= 1'b1;
                r_clrAddr <= '0;
            end else begin
                r_clrAddr <= r_clrAddr + 1'b1;
            end
        end else begin
            r_readValid <= w_accept & memRead;
            r_addrError <= w_accept & ~w_inRange;
            if (w_accept & memRead) begin
                if (!w_inRange) begin
                    r_readData <= '0;
                end else if (memWrite) begin
                    r_readData <= w_merged;
                end else begin
                    r_readData <= w_oldWord;
                end
            end
        end
    end

    // Array write port: zero-fill during clear, merged store when idle.
    // Out-of-range stores are dropped here.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clrAddr[ADDR_WIDTH-1:0]] <= '0;
        end else if (w_accept & memWrite & w_inRange) begin
            r_mem[address] <= w_merged;
        end
    end

    assign ready     = r_ready;
    assign readData  = r_readData;
    assign readValid = r_readValid;
    assign addrError = r_addrError;

endmodule
